// File: rtl/mau_pkg.sv
// Shared definitions for the MEM-stage load/store sequencer: access-size
// encoding, fault codes, FSM state type and the size-to-byte-count helper.
package mau_pkg;

  localparam int MAU_MEM_BYTES = 128;
  localparam int MAU_DATA_W    = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_RANGE    = 2'b10;
  localparam logic [1:0] FC_SIZE     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_RESP = 2'b10,
    ST_WR   = 2'b11
  } mau_state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mau_lane_fmt.sv
// Big-endian lane formatter: extracts and extends sub-word loads and merges
// sub-word store data into a captured memory word.
module mau_lane_fmt
  import mau_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        sign_ext_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte offset k lives in bits [31-8k -: 8]; halves at offset 0 / 2.
  always_comb begin
    byte_s      = 8'h00;
    half_s      = 16'h0000;
    load_data_o = rdata_i;
    merged_o    = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        case (offset_i)
          2'd0:    begin byte_s = rdata_i[31:24]; merged_o[31:24] = wdata_i[7:0]; end
          2'd1:    begin byte_s = rdata_i[23:16]; merged_o[23:16] = wdata_i[7:0]; end
          2'd2:    begin byte_s = rdata_i[15:8];  merged_o[15:8]  = wdata_i[7:0]; end
          default: begin byte_s = rdata_i[7:0];   merged_o[7:0]   = wdata_i[7:0]; end
        endcase
        load_data_o = {{24{sign_ext_i & byte_s[7]}}, byte_s};
      end
      SZ_HALF: begin
        if (offset_i[1]) begin
          half_s         = rdata_i[15:0];
          merged_o[15:0] = wdata_i[15:0];
        end else begin
          half_s          = rdata_i[31:16];
          merged_o[31:16] = wdata_i[15:0];
        end
        load_data_o = {{16{sign_ext_i & half_s[15]}}, half_s};
      end
      default: begin
        load_data_o = rdata_i;
        merged_o    = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer in front of a big-endian data memory.
// Optional macro MAU_ALIGN_CHECK_EN enables misalignment faults; otherwise low address bits are forced to 0.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = MAU_MEM_BYTES,
  parameter int DATA_W    = MAU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic [31:0]       dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_read,
  output logic              dm_write,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              fault,
  output logic [1:0]        fault_code
);

  mau_state_e state_q, state_d;
  logic        we_q, we_d, sgn_q, sgn_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic [31:0] st_data_q, st_data_d, dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [31:0] load_data_q, load_data_d;
  logic        dm_read_q, dm_read_d, dm_write_q, dm_write_d;
  logic        load_valid_q, load_valid_d, fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic        ready_q, ready_d, stall_q, stall_d;

  logic [32:0] end_s;
  logic [1:0]  req_off_s, chk_code_s;
  logic        align_bad_s;
  logic [31:0] fmt_load_s, fmt_merged_s;

  mau_lane_fmt u_lane_fmt (
    .size_i      (size_q),
    .offset_i    (off_q),
    .sign_ext_i  (sgn_q),
    .rdata_i     (dm_rdata),
    .wdata_i     (st_data_q),
    .load_data_o (fmt_load_s),
    .merged_o    (fmt_merged_s)
  );

  // Request screening; 33-bit end address so top-of-space addresses cannot wrap into range.
  always_comb begin
    end_s       = {1'b0, req_addr} + {30'b0, size_bytes(req_size)};
    req_off_s   = req_addr[1:0];
    align_bad_s = 1'b0;
    if (req_size == SZ_HALF) begin
`ifdef MAU_ALIGN_CHECK_EN
      align_bad_s = req_addr[0];
`else
      req_off_s = {req_addr[1], 1'b0};
`endif
    end else if (req_size == SZ_WORD) begin
`ifdef MAU_ALIGN_CHECK_EN
      align_bad_s = |req_addr[1:0];
`else
      req_off_s = 2'b00;
`endif
    end else begin
      req_off_s = req_addr[1:0];
    end
    if (req_size == SZ_RSVD) begin
      chk_code_s = FC_SIZE;
    end else if (end_s > 33'(MEM_BYTES)) begin
      chk_code_s = FC_RANGE;
    end else if (align_bad_s) begin
      chk_code_s = FC_MISALIGN;
    end else begin
      chk_code_s = FC_NONE;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    sgn_d        = sgn_q;
    size_d       = size_q;
    off_d        = off_q;
    st_data_d    = st_data_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    load_data_d  = load_data_q;
    fault_code_d = fault_code_q;
    dm_read_d    = 1'b0;
    dm_write_d   = 1'b0;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          if (chk_code_s != FC_NONE) begin
            fault_d      = 1'b1;
            fault_code_d = chk_code_s;
          end else begin
            we_d      = req_we;
            sgn_d     = req_signed;
            size_d    = req_size;
            off_d     = req_off_s;
            st_data_d = req_wdata;
            dm_addr_d = {req_addr[31:2], 2'b00};
            if (req_we && (req_size == SZ_WORD)) begin
              dm_wdata_d = req_wdata;
              dm_write_d = 1'b1;
              state_d    = ST_WR;
            end else begin
              dm_read_d = 1'b1;
              state_d   = ST_RD;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (we_q) begin
          dm_wdata_d = fmt_merged_s;
          dm_write_d = 1'b1;
          state_d    = ST_WR;
        end else begin
          load_data_d  = fmt_load_s;
          load_valid_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    stall_d = ~ready_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      sgn_q        <= 1'b0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      st_data_q    <= 32'h0000_0000;
      dm_addr_q    <= 32'h0000_0000;
      dm_wdata_q   <= 32'h0000_0000;
      load_data_q  <= 32'h0000_0000;
      dm_read_q    <= 1'b0;
      dm_write_q   <= 1'b0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
      ready_q      <= 1'b1;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      sgn_q        <= sgn_d;
      size_q       <= size_d;
      off_q        <= off_d;
      st_data_q    <= st_data_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      load_data_q  <= load_data_d;
      dm_read_q    <= dm_read_d;
      dm_write_q   <= dm_write_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
      ready_q      <= ready_d;
      stall_q      <= stall_d;
    end
  end

  assign req_ready  = ready_q;
  assign stall      = stall_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign dm_read    = dm_read_q;
  assign dm_write   = dm_write_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard, with
// hand-written back-to-back and mid-operation reset sequences.
module tb_mem_access_unit;

  localparam int K_LOAD  = 0;
  localparam int K_FAULT = 1;
  localparam int K_WRITE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, stall, dm_read, dm_write, load_valid, fault;
  logic [31:0] dm_addr, dm_wdata, load_data;
  logic [31:0] dm_rdata = 32'h0;
  logic [1:0]  fault_code;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_read(dm_read),
    .dm_write(dm_write), .dm_rdata(dm_rdata), .load_data(load_data),
    .load_valid(load_valid), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          kind;
    logic [31:0] data;
    logic [31:0] eaddr;
    int          lat;
    int          reads;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[$];
  logic [31:0] mem [0:31];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Data memory model: read data valid the cycle after dm_read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dm_read) dm_rdata <= mem[dm_addr[6:2]];
    if (dm_write) mem[dm_addr[6:2]] <= dm_wdata;
  end

  task automatic sb_match(input int kind, input logic [31:0] data, input logic [31:0] addr);
    exp_t e;
    if (sb.size() == 0) begin
      fail_now($sformatf("unexpected_output kind=%0d data=0x%08h", kind, data));
    end else begin
      e = sb.pop_front();
      chk("out_kind", 32'(kind), 32'(e.kind));
      chk("out_data", data, e.data);
      chk("out_cycle", 32'(cyc), 32'(e.cyc));
      if (kind == K_WRITE) chk("write_addr", addr, e.addr);
    end
  endtask

  // Output monitor: pops the scoreboard as results appear, flags overdue entries.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dm_read) rd_cnt++;
      if (dm_write) wr_cnt++;
      if (load_valid) sb_match(K_LOAD, load_data, 32'h0);
      if (fault) sb_match(K_FAULT, {30'b0, fault_code}, 32'h0);
      if (dm_write) sb_match(K_WRITE, dm_wdata, dm_addr);
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        fail_now($sformatf("missing_output kind=%0d expected_cycle=%0d", sb[0].kind, sb[0].cyc));
        void'(sb.pop_front());
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata, input int kind,
                              input logic [31:0] data, input logic [31:0] eaddr, input int lat,
                              input int reads);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.kind = kind; v.data = data; v.eaddr = eaddr; v.lat = lat; v.reads = reads;
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) fail_now("timeout_waiting_ready");
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0 || !req_ready) fail_now("timeout_draining");
    @(negedge clk);
  endtask

  task automatic drive(input vec_t v);
    req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.kind = v.kind; e.data = v.data; e.addr = v.eaddr; e.cyc = cyc + v.lat;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int rc0;
    wait_ready();
    rc0 = rd_cnt;
    drive(v);
    push_exp(v);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    chk($sformatf("dm_read_count[%0d]", idx), 32'(rd_cnt - rc0), 32'(v.reads));
  endtask

  initial begin
    vec_t v;
    int   wc0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[31] = 32'h1122_3344;

    vt.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, K_WRITE, 32'hDEADBEEF, 32'h10, 1, 0));
    vt.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, K_LOAD, 32'hDEADBEEF, 32'h0, 3, 1));
    vt.push_back(mk(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, K_LOAD, 32'hFFFFFFAD, 32'h0, 3, 1));
    vt.push_back(mk(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, K_LOAD, 32'h000000AD, 32'h0, 3, 1));
    vt.push_back(mk(1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234, K_WRITE, 32'hDEAD1234, 32'h10, 3, 1));
    vt.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, K_LOAD, 32'h00001234, 32'h0, 3, 1));
`ifdef MAU_ALIGN_CHECK_EN
    vt.push_back(mk(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, K_FAULT, 32'h1, 32'h0, 1, 0));
`else
    vt.push_back(mk(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, K_LOAD, 32'h00001234, 32'h0, 3, 1));
`endif
    vt.push_back(mk(1'b0, 2'b10, 1'b0, 32'h7E, 32'h0, K_FAULT, 32'h2, 32'h0, 1, 0));
    vt.push_back(mk(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, K_FAULT, 32'h3, 32'h0, 1, 0));
    vt.push_back(mk(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5, K_WRITE, 32'hDEAD12A5, 32'h10, 3, 1));
    vt.push_back(mk(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, K_LOAD, 32'hFFFFFFA5, 32'h0, 3, 1));
    vt.push_back(mk(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, K_LOAD, 32'hFFFFDEAD, 32'h0, 3, 1));
    vt.push_back(mk(1'b0, 2'b00, 1'b0, 32'h7F, 32'h0, K_LOAD, 32'h00000044, 32'h0, 3, 1));
    vt.push_back(mk(1'b0, 2'b01, 1'b0, 32'h7E, 32'h0, K_LOAD, 32'h00003344, 32'h0, 3, 1));
    vt.push_back(mk(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, K_FAULT, 32'h2, 32'h0, 1, 0));
    vt.push_back(mk(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF8001, K_WRITE, 32'h800112A5, 32'h10, 3, 1));
    vt.push_back(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, K_LOAD, 32'h800112A5, 32'h0, 3, 1));
    vt.push_back(mk(1'b0, 2'b11, 1'b0, 32'h81, 32'h0, K_FAULT, 32'h3, 32'h0, 1, 0));
    vt.push_back(mk(1'b1, 2'b10, 1'b0, 32'h7D, 32'h0, K_FAULT, 32'h2, 32'h0, 1, 0));
    vt.push_back(mk(0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, K_FAULT, 32'h2, 32'h0, 1, 0));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_dm_strobes", {30'b0, dm_read, dm_write}, 32'h0);
    chk("rst_pulses", {30'b0, load_valid, fault}, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) run_vec(vt[i], i);

    // Back-to-back: req_valid held high, second request taken when ready returns.
    wait_ready();
    v = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, K_LOAD, 32'h800112A5, 32'h0, 3, 1);
    drive(v);
    push_exp(v);
    @(negedge clk);
    v = mk(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, K_LOAD, 32'h00000001, 32'h0, 3, 1);
    drive(v);
    chk("b2b_stall_c1", {31'b0, stall}, 32'h1);
    chk("b2b_ready_c1", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    chk("b2b_stall_c2", {31'b0, stall}, 32'h1);
    @(negedge clk);
    chk("b2b_ready_c3", {31'b0, req_ready}, 32'h1);
    chk("b2b_load_valid_c3", {31'b0, load_valid}, 32'h1);
    push_exp(v);
    @(negedge clk);
    chk("b2b_stall_c4", {31'b0, stall}, 32'h1);
    chk("b2b_dm_read_c4", {31'b0, dm_read}, 32'h1);
    req_valid = 1'b0;
    drain();

    // Reset while a byte store sits in RD.
    wait_ready();
    wc0 = wr_cnt;
    drive(mk(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000005A, K_WRITE, 32'h0, 32'h0, 3, 1));
    @(negedge clk);
    req_valid = 1'b0;
    chk("rdrst_dm_read_before", {31'b0, dm_read}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rdrst_dm_read_after", {31'b0, dm_read}, 32'h0);
    chk("rdrst_dm_write_after", {31'b0, dm_write}, 32'h0);
    chk("rdrst_ready_in_reset", {31'b0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rdrst_no_write", 32'(wr_cnt - wc0), 32'h0);
    chk("rdrst_ready_after", {31'b0, req_ready}, 32'h1);
    run_vec(mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, K_LOAD, 32'h800112A5, 32'h0, 3, 1), 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store sequencer, directly upstream of the 128-byte big-endian data memory.
- Converts pipeline byte/half/word load and store requests into word-aligned data-memory read/write cycles.
- Performs read-modify-write for sub-word stores and extracts/sign-extends sub-word loads.
- Stalls the pipeline while busy and flags misaligned or out-of-range accesses.

Parameters:
- MEM_BYTES, 128: data-memory size in bytes; accesses with addr >= MEM_BYTES fault.
- DATA_W, 32: word width; fixed at 32, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present from EX/MEM register.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  load sign-extend (ignored for word and store).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready at a clk edge.
- stall  out  1  equals !req_ready.
- dm_addr  out  32  word-aligned address to data memory ({req_addr[31:2],2'b00}).
- dm_wdata  out  32  big-endian word to data memory.
- dm_read  out  1  read strobe; dm_rdata valid the cycle after.
- dm_write  out  1  write strobe, one cycle.
- dm_rdata  in  32  data from data memory.
- load_data  out  32  formatted load result.
- load_valid  out  1  one-cycle pulse with load_data.
- fault  out  1  one-cycle pulse on rejected request.
- fault_code  out  2  01 misaligned, 10 out of range, 11 reserved size; valid with fault.

Behaviour:
- All outputs registered.
- Reset values: all outputs 0 except req_ready=1; state IDLE.
- Reset mid-operation drops the pending request; dm_read and dm_write fall immediately.
- Lane mapping is big-endian:
  - Byte offset k maps to bits [31-8k -: 8].
  - Half at offset 0 maps to [31:16]; half at offset 2 maps to [15:0].
- Fault checks at accept, priority order: size 11 -> code 11; then addr+bytes > MEM_BYTES -> 10; then half with addr[0]!=0, or word with addr[1:0]!=0 -> 01.
  - On fault: no memory access; state stays IDLE; fault pulses the next cycle.
- FSM states: IDLE, RD, RESP, WR.
  - IDLE: on accept, latch request. Load or sub-word store -> RD; word store -> WR.
  - RD: dm_read=1 -> RESP.
  - RESP, load: format dm_rdata (select lane, sign- or zero-extend) into load_data; pulse load_valid for one cycle after the edge; -> IDLE.
  - RESP, sub-word store: merge the low bytes of req_wdata into the captured word at the lane; other lanes unchanged; -> WR.
  - WR: dm_write=1, dm_wdata=word -> IDLE.
- Latency from accept edge:
  - Load: load_valid 3 cycles later.
  - Word store: dm_write in cycle 1.
  - Sub-word store: dm_write in cycle 3.
- A new request may be accepted in the same cycle load_valid is high.
- req_valid deasserting while busy has no effect; latched values are used.

Optional Feature:
- MAU_ALIGN_CHECK_EN:
  - Defined: misalignment faults as above.
  - Undefined: misalignment never faults; low address bits are forced to 0 for half (addr[0]) and word (addr[1:0]) accesses.
- Range and size checks are present in both builds.

Decomposition:
- Shared package mau_pkg: size encoding constants, state enum, fault_code constants.
- One combinational sub-module, mau_lane_fmt: load extract/extend and store merge, driven by size, offset and signed.
- FSM and registers stay in mem_access_unit.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> dm_write in cycle 1 with dm_wdata=0xDEADBEEF; load_valid at +3 with load_data=0xDEADBEEF.
- Byte load @0x11, signed then unsigned, memory word 0xDEADBEEF -> load_data 0xFFFFFFAD, then 0x000000AD.
- Half store 0x00001234 @0x12 over 0xDEADBEEF -> dm_read, then dm_write of 0xDEAD1234; half load @0x12 signed -> 0x00001234.
- Half load @0x13 -> fault with code 01, no dm strobes. Word load @0x7E -> code 10. Size 11 -> code 11.
- Reset asserted while in RD during a byte store -> dm_read=0 immediately; no dm_write occurs; after release req_ready=1.
- Back-to-back requests with req_valid held high -> stall high through RD/RESP/WR; second request accepted on the first edge with req_ready=1.
